// File: rtl/bram_port_arbiter.sv
// Shares BRAM port B between the CPU load/store FSM and the debug loader.
// CPU has priority; a wait counter and a loader lock bound the loader's latency.
module bram_port_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 16,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] PRI_CPU   = 2'd0;
  localparam logic [1:0] FORCE_DBG = 2'd1;
  localparam logic [1:0] LOCKED    = 2'd2;

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       last_addr_q, last_addr_d;
  logic [DW-1:0]       last_wdata_q, last_wdata_d;
  // Read-return pipe: valid bit and owner (1 = loader) per stage.
  logic [READ_LAT-1:0] pipe_v_q, pipe_o_q;

  logic cpu_win, dbg_win;
  logic rd_push;
  logic dbg_inflight;

  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    case (state_q)
      PRI_CPU: begin
        cpu_win = cpu_req;
        dbg_win = dbg_req & ~cpu_req;
      end
      FORCE_DBG: begin
        dbg_win = dbg_req;
        cpu_win = cpu_req & ~dbg_req;
      end
      LOCKED: begin
        dbg_win = dbg_req;
      end
      default: begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
      end
    endcase
  end

  // Grants are masked during reset so the BRAM sees no access.
  assign cpu_gnt = cpu_win & ~rst;
  assign dbg_gnt = dbg_win & ~rst;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = last_addr_q;
    mem_wdata = last_wdata_q;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign last_addr_d  = mem_addr;
  assign last_wdata_d = mem_wdata;

  assign rd_push = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);

  // Loader reads still owed after this edge; the last stage retires now.
  always_comb begin
    dbg_inflight = dbg_gnt & ~dbg_we;
    for (int i = 0; i < int'(READ_LAT) - 1; i++) begin
      dbg_inflight = dbg_inflight | (pipe_v_q[i] & pipe_o_q[i]);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!dbg_req || dbg_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != MAX_CNT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (dbg_gnt && dbg_lock) begin
      state_d = LOCKED;
    end else begin
      case (state_q)
        PRI_CPU: begin
          if (cnt_d == MAX_CNT) state_d = FORCE_DBG;
        end
        FORCE_DBG: begin
          if (dbg_gnt || !dbg_req) state_d = PRI_CPU;
        end
        LOCKED: begin
          if (!dbg_lock && !dbg_inflight) state_d = PRI_CPU;
        end
        default: state_d = PRI_CPU;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PRI_CPU;
      cnt_q        <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_addr_q  <= last_addr_d;
      last_wdata_q <= last_wdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v_q <= '0;
      pipe_o_q <= '0;
    end else begin
      for (int i = int'(READ_LAT) - 1; i > 0; i--) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_o_q[i] <= pipe_o_q[i-1];
      end
      pipe_v_q[0] <= rd_push;
      pipe_o_q[0] <= dbg_gnt;
    end
  end

  assign cpu_rvalid = pipe_v_q[READ_LAT-1] & ~pipe_o_q[READ_LAT-1] & ~rst;
  assign dbg_rvalid = pipe_v_q[READ_LAT-1] &  pipe_o_q[READ_LAT-1] & ~rst;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a one-cycle-latency BRAM model.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [9:0]  dbg_addr;
  logic [15:0] dbg_wdata, dbg_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [0:1023];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.AW(10), .DW(16), .READ_LAT(1), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous BRAM port B; preload contents while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      mem[10'h000] <= 16'hA000;
      mem[10'h001] <= 16'hA001;
      mem[10'h002] <= 16'hA002;
      mem[10'h010] <= 16'hBEEF;
      mem[10'h030] <= 16'h5A5A;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF; cpu_wdata = 16'hFFFF;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h155; dbg_wdata = 16'h1111; dbg_lock = 1'b0;
    #3;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_dbg_gnt", 32'(dbg_gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    tick(); tick();
    rst = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;

    // 1: single cpu read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    #1;
    chk("t1_cpu_gnt", 32'(cpu_gnt), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h010);
    chk("t1_mem_we", 32'(mem_we), 0);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("t1_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("t1_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    chk("t1_dbg_rvalid", 32'(dbg_rvalid), 0);
    chk("t1_addr_hold", 32'(mem_addr), 32'h010);
    tick();
    chk("t1_rvalid_gone", 32'(cpu_rvalid), 0);

    // 2: contention, 4 cpu grants then 1 forced dbg grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h001;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t2_cpu_gnt_%0d", i), 32'(cpu_gnt), (i % 5 == 4) ? 0 : 1);
      chk($sformatf("t2_dbg_gnt_%0d", i), 32'(dbg_gnt), (i % 5 == 4) ? 1 : 0);
      tick();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick(); tick();

    // 3: locked dbg write blocks cpu until lock drops
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h020; dbg_wdata = 16'h1234; dbg_lock = 1'b1;
    #1;
    chk("t3_dbg_gnt", 32'(dbg_gnt), 1);
    chk("t3_mem_we", 32'(mem_we), 1);
    chk("t3_mem_addr", 32'(mem_addr), 32'h020);
    chk("t3_mem_wdata", 32'(mem_wdata), 32'h1234);
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
    #1;
    chk("t3_cpu_blocked0", 32'(cpu_gnt), 0);
    chk("t3_mem_we_idle", 32'(mem_we), 0);
    tick();
    chk("t3_cpu_blocked1", 32'(cpu_gnt), 0);
    dbg_lock = 1'b0;
    #1;
    chk("t3_cpu_blocked2", 32'(cpu_gnt), 0);
    tick();
    chk("t3_cpu_gnt", 32'(cpu_gnt), 1);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("t3_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("t3_cpu_rdata", 32'(cpu_rdata), 32'h1234);
    tick();

    // 4: back-to-back cpu reads
    cpu_req = 1'b1; cpu_addr = 10'h000;
    #1;
    chk("t4_gnt0", 32'(cpu_gnt), 1);
    tick();
    cpu_addr = 10'h001;
    #1;
    chk("t4_gnt1", 32'(cpu_gnt), 1);
    chk("t4_rv0", 32'(cpu_rvalid), 1);
    chk("t4_rd0", 32'(cpu_rdata), 32'hA000);
    tick();
    cpu_addr = 10'h002;
    #1;
    chk("t4_rv1", 32'(cpu_rvalid), 1);
    chk("t4_rd1", 32'(cpu_rdata), 32'hA001);
    chk("t4_dbg_rv1", 32'(dbg_rvalid), 0);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("t4_rv2", 32'(cpu_rvalid), 1);
    chk("t4_rd2", 32'(cpu_rdata), 32'hA002);
    chk("t4_dbg_rv2", 32'(dbg_rvalid), 0);
    tick();
    chk("t4_rv_end", 32'(cpu_rvalid), 0);

    // 5: reset while a read is in flight
    cpu_req = 1'b1; cpu_addr = 10'h010;
    #1;
    chk("t5_gnt", 32'(cpu_gnt), 1);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_rvalid", 32'(cpu_rvalid), 0);
    chk("t5_rst_gnt", 32'(cpu_gnt), 0);
    chk("t5_rst_dbg_gnt", 32'(dbg_gnt), 0);
    chk("t5_rst_mem_we", 32'(mem_we), 0);
    chk("t5_rst_mem_addr", 32'(mem_addr), 0);
    chk("t5_rst_mem_wdata", 32'(mem_wdata), 0);
    tick();
    rst = 1'b0; cpu_req = 1'b0;
    #1;
    chk("t5_no_rvalid0", 32'(cpu_rvalid), 0);
    tick();
    chk("t5_no_rvalid1", 32'(cpu_rvalid), 0);
    cpu_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h001;
    #1;
    chk("t5_pri_cpu", 32'(cpu_gnt), 1);
    chk("t5_pri_dbg", 32'(dbg_gnt), 0);
    tick();
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick(); tick();

    // 6: locked dbg read, lock dropped with the read
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h031; dbg_wdata = 16'h7777; dbg_lock = 1'b1;
    #1;
    chk("t6_wr_gnt", 32'(dbg_gnt), 1);
    tick();
    dbg_we = 1'b0; dbg_addr = 10'h030; dbg_lock = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h002;
    #1;
    chk("t6_rd_gnt", 32'(dbg_gnt), 1);
    chk("t6_cpu_blocked0", 32'(cpu_gnt), 0);
    tick();
    dbg_req = 1'b0;
    #1;
    chk("t6_dbg_rvalid", 32'(dbg_rvalid), 1);
    chk("t6_dbg_rdata", 32'(dbg_rdata), 32'h5A5A);
    chk("t6_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("t6_cpu_blocked1", 32'(cpu_gnt), 0);
    tick();
    chk("t6_cpu_gnt", 32'(cpu_gnt), 1);
    chk("t6_dbg_rv_end", 32'(dbg_rvalid), 0);
    tick();
    cpu_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
